// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the memory request arbiter: FSM states, grant
// selector, memory-unit bus widths and the default mapped-address ceiling.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 27;
    localparam int MEM_DATA_W = 32;

    localparam logic [MEM_ADDR_W-1:0] DEFAULT_ADDR_LIMIT = 27'hC01600;

    typedef enum logic [2:0] {
        INIT_WAIT,
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_t;

    // Anything at or above the limit has no backing device behind the memory unit.
    function automatic logic addr_unmapped(input logic [MEM_ADDR_W-1:0] addr,
                                           input logic [MEM_ADDR_W-1:0] limit);
        return (addr >= limit);
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Fetch/data requester pick with a bounded data streak so a busy data port
// cannot starve instruction fetch indefinitely.
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   arb_en,
    input  logic   if_req,
    input  logic   d_req,
    output logic   gnt_valid,
    output grant_t gnt_sel
);

    localparam int STREAK_W = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    logic [STREAK_W-1:0] streak_reg;
    logic [STREAK_W-1:0] streak_next;
    logic                streak_full;

    assign streak_full = (streak_reg == STREAK_MAX);

    always_comb begin
        gnt_valid   = arb_en && (if_req || d_req);
        gnt_sel     = GNT_IF;
        streak_next = streak_reg;

        // Data wins ties until it has used up its streak against a waiting fetch.
        if (d_req && !(if_req && streak_full)) begin
            gnt_sel = GNT_D;
        end

        if (gnt_valid) begin
            if (gnt_sel == GNT_IF) begin
                streak_next = '0;
            end else if (if_req && !streak_full) begin
                streak_next = streak_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak_reg <= '0;
        end else begin
            streak_reg <= streak_next;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates instruction-fetch and data ports onto the single start/busy
// memory-unit interface, with local rejection of unmapped addresses and a hang timeout.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                    TIMEOUT_CYCLES  = 4096,
    parameter int                    MAX_DATA_STREAK = 4,
    parameter logic [MEM_ADDR_W-1:0] ADDR_LIMIT      = DEFAULT_ADDR_LIMIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [MEM_ADDR_W-1:0] if_addr,
    output logic                  if_ack,
    output logic [MEM_DATA_W-1:0] if_q,
    input  logic                  d_req,
    input  logic [MEM_ADDR_W-1:0] d_addr,
    input  logic [MEM_DATA_W-1:0] d_data,
    input  logic                  d_we,
    output logic                  d_ack,
    output logic [MEM_DATA_W-1:0] d_q,
    output logic                  bus_err,
    output logic [MEM_ADDR_W-1:0] mu_address,
    output logic [MEM_DATA_W-1:0] mu_data,
    output logic                  mu_we,
    output logic                  mu_start,
    input  logic                  mu_busy,
    input  logic [MEM_DATA_W-1:0] mu_q,
    input  logic                  mu_init_done
);

    localparam int NPORT = 2;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    arb_state_t            state_reg, state_next;
    grant_t                gnt_reg, gnt_next;
    logic [TMO_W-1:0]      tmo_cnt_reg, tmo_cnt_next, tmo_inc;
    logic [MEM_ADDR_W-1:0] mu_address_reg, mu_address_next;
    logic [MEM_DATA_W-1:0] mu_data_reg, mu_data_next;
    logic                  mu_we_reg, mu_we_next;
    logic                  mu_start_reg, mu_start_next;
    logic [NPORT-1:0]      ack_reg, ack_next;
    logic                  bus_err_reg, bus_err_next;

    logic [NPORT-1:0]                 q_load;
    logic [MEM_DATA_W-1:0]            q_load_val;
    logic [NPORT-1:0][MEM_DATA_W-1:0] q_all;

    logic                  gnt_valid;
    grant_t                gnt_sel;
    logic [MEM_ADDR_W-1:0] req_addr;

    mem_arb_grant #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_grant (
        .clk      (clk),
        .reset    (reset),
        .arb_en   (state_reg == IDLE),
        .if_req   (if_req),
        .d_req    (d_req),
        .gnt_valid(gnt_valid),
        .gnt_sel  (gnt_sel)
    );

    assign req_addr = (gnt_sel == GNT_D) ? d_addr : if_addr;
    assign tmo_inc  = tmo_cnt_reg + 1'b1;

    always_comb begin
        state_next      = state_reg;
        gnt_next        = gnt_reg;
        tmo_cnt_next    = '0;
        mu_address_next = mu_address_reg;
        mu_data_next    = mu_data_reg;
        mu_we_next      = mu_we_reg;
        mu_start_next   = 1'b0;
        ack_next        = '0;
        bus_err_next    = 1'b0;
        q_load          = '0;
        q_load_val      = '0;

        case (state_reg)
            INIT_WAIT: begin
                if (mu_init_done) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (gnt_valid) begin
                    gnt_next        = gnt_sel;
                    mu_address_next = req_addr;
                    mu_data_next    = (gnt_sel == GNT_D) ? d_data : '0;
                    if (addr_unmapped(req_addr, ADDR_LIMIT)) begin
                        // Never reaches the memory unit; a write here is simply dropped.
                        mu_we_next       = 1'b0;
                        q_load[gnt_sel]  = 1'b1;
                        ack_next[gnt_sel] = 1'b1;
                        bus_err_next     = 1'b1;
                        state_next       = DONE;
                    end else begin
                        mu_we_next    = (gnt_sel == GNT_D) && d_we;
                        mu_start_next = 1'b1;
                        state_next    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (tmo_inc == TMO_LIMIT) begin
                    q_load[gnt_reg]   = 1'b1;
                    ack_next[gnt_reg] = 1'b1;
                    bus_err_next      = 1'b1;
                    state_next        = DONE;
                end else begin
                    mu_start_next = 1'b1;
                    tmo_cnt_next  = tmo_inc;
                    if (mu_busy) begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                // Completion is checked first so a late finish on the timeout edge still counts.
                if (!mu_busy) begin
                    q_load[gnt_reg]   = 1'b1;
                    q_load_val        = mu_q;
                    ack_next[gnt_reg] = 1'b1;
                    state_next        = DONE;
                end else if (tmo_inc == TMO_LIMIT) begin
                    q_load[gnt_reg]   = 1'b1;
                    ack_next[gnt_reg] = 1'b1;
                    bus_err_next      = 1'b1;
                    state_next        = DONE;
                end else begin
                    mu_start_next = 1'b1;
                    tmo_cnt_next  = tmo_inc;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = INIT_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= INIT_WAIT;
            gnt_reg        <= GNT_IF;
            tmo_cnt_reg    <= '0;
            mu_address_reg <= '0;
            mu_data_reg    <= '0;
            mu_we_reg      <= 1'b0;
            mu_start_reg   <= 1'b0;
            ack_reg        <= '0;
            bus_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            gnt_reg        <= gnt_next;
            tmo_cnt_reg    <= tmo_cnt_next;
            mu_address_reg <= mu_address_next;
            mu_data_reg    <= mu_data_next;
            mu_we_reg      <= mu_we_next;
            mu_start_reg   <= mu_start_next;
            ack_reg        <= ack_next;
            bus_err_reg    <= bus_err_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_port_q
            logic [MEM_DATA_W-1:0] q_port_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    q_port_reg <= '0;
                end else if (q_load[gi]) begin
                    q_port_reg <= q_load_val;
                end
            end

            assign q_all[gi] = q_port_reg;
        end
    endgenerate

    assign if_ack     = ack_reg[GNT_IF];
    assign d_ack      = ack_reg[GNT_D];
    assign if_q       = q_all[GNT_IF];
    assign d_q        = q_all[GNT_D];
    assign bus_err    = bus_err_reg;
    assign mu_address = mu_address_reg;
    assign mu_data    = mu_data_reg;
    assign mu_we      = mu_we_reg;
    assign mu_start   = mu_start_reg;

    // A client must keep its request up while the memory unit is working for it.
    a_req_held: assert property (@(posedge clk) disable iff (!reset)
        (state_reg == ISSUE || state_reg == WAIT) |-> ((gnt_reg == GNT_D) ? d_req : if_req));

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a negedge memory-unit model
// (single-negedge busy, or busy stuck high for timeout scenarios).
module tb_mem_req_arbiter;
    import mem_arb_pkg::*;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [26:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_q;
    logic        d_req = 1'b0;
    logic [26:0] d_addr = '0;
    logic [31:0] d_data = '0;
    logic        d_we = 1'b0;
    logic        d_ack;
    logic [31:0] d_q;
    logic        bus_err;
    logic [26:0] mu_address;
    logic [31:0] mu_data;
    logic        mu_we;
    logic        mu_start;
    logic        mu_busy = 1'b0;
    logic [31:0] mu_q = '0;
    logic        mu_init_done = 1'b0;

    logic mem_stuck = 1'b0;
    logic mem_served = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   both_ack_cnt = 0;
    int   start_cycles = 0;

    mem_req_arbiter #(
        .TIMEOUT_CYCLES (TMO),
        .MAX_DATA_STREAK(4),
        .ADDR_LIMIT     (27'hC01600)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_ack      (if_ack),
        .if_q        (if_q),
        .d_req       (d_req),
        .d_addr      (d_addr),
        .d_data      (d_data),
        .d_we        (d_we),
        .d_ack       (d_ack),
        .d_q         (d_q),
        .bus_err     (bus_err),
        .mu_address  (mu_address),
        .mu_data     (mu_data),
        .mu_we       (mu_we),
        .mu_start    (mu_start),
        .mu_busy     (mu_busy),
        .mu_q        (mu_q),
        .mu_init_done(mu_init_done)
    );

    always #5 clk = ~clk;

    // Memory unit: reacts on negedge, busy for one negedge unless stuck.
    always @(negedge clk) begin
        if (!mu_start) begin
            mu_busy    <= 1'b0;
            mem_served <= 1'b0;
        end else if (mem_stuck) begin
            mu_busy <= 1'b1;
        end else if (!mem_served) begin
            mu_busy    <= 1'b1;
            mem_served <= 1'b1;
        end else begin
            mu_busy <= 1'b0;
        end
        if (mu_start) start_cycles <= start_cycles + 1;
        if (if_ack && d_ack) both_ack_cnt <= both_ack_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ack(input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!(if_ack || d_ack) && cyc < max_cyc);
        check_val("ack_seen", 32'(if_ack | d_ack), 1);
        $display("[%0t] txn if_ack=%0b d_ack=%0b bus_err=%0b if_q=%h d_q=%h addr=%h cycles=%0d",
                 $time, if_ack, d_ack, bus_err, if_q, d_q, mu_address, cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int s0;
        int n_acks;
        int got_order[10];
        int ack_cyc[10];
        int exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        // Reset state
        step(3);
        check_val("rst_ctrl", 32'({if_ack, d_ack, bus_err, mu_start, mu_we}), 0);
        check_val("rst_if_q", if_q, 0);
        check_val("rst_d_q", d_q, 0);
        check_val("rst_addr", 32'(mu_address), 0);

        // Held in INIT_WAIT until the memory unit reports init done
        @(negedge clk);
        reset   = 1'b1;
        if_addr = 27'h000100;
        if_req  = 1'b1;
        mu_q    = 32'h12345678;
        s0 = start_cycles;
        step(5);
        check_val("init_no_start", 32'(start_cycles - s0), 0);
        mu_init_done = 1'b1;
        step(1);
        check_val("init_to_idle", 32'(mu_start), 0);
        step(1);
        check_val("init_grant", 32'(mu_start), 1);
        wait_ack(10, cyc);
        check_val("init_if_ack", 32'({if_ack, d_ack, bus_err}), 32'b100);
        check_val("init_if_q", if_q, 32'h12345678);
        check_val("init_latency", 32'(cyc), 2);
        if_req = 1'b0;
        step(1);
        check_val("init_ack_pulse", 32'(if_ack), 0);

        // Fast data read
        mu_q   = 32'hCAFEF00D;
        d_addr = 27'hC00000;
        d_we   = 1'b0;
        d_req  = 1'b1;
        s0 = start_cycles;
        wait_ack(10, cyc);
        check_val("rd_acks", 32'({if_ack, d_ack, bus_err}), 32'b010);
        check_val("rd_d_q", d_q, 32'hCAFEF00D);
        check_val("rd_addr_held", 32'(mu_address), 32'h00C00000);
        check_val("rd_start_cycles", 32'(start_cycles - s0), 2);
        d_req = 1'b0;
        step(1);
        check_val("rd_ack_pulse", 32'(d_ack), 0);

        // Both requesters held: data streak of 4 then a forced fetch
        mu_q    = 32'h0A0A0A0A;
        if_addr = 27'h000200;
        d_addr  = 27'h000300;
        if_req  = 1'b1;
        d_req   = 1'b1;
        n_acks  = 0;
        cyc     = 0;
        while (n_acks < 10 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (if_ack || d_ack) begin
                got_order[n_acks] = d_ack ? 1 : 0;
                ack_cyc[n_acks]   = cyc;
                n_acks++;
                $display("[%0t] txn arb if_ack=%0b d_ack=%0b addr=%h", $time, if_ack, d_ack, mu_address);
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        check_val("arb_ack_count", 32'(n_acks), 10);
        for (int i = 0; i < 10; i++) begin
            check_val($sformatf("arb_order_%0d", i), 32'(got_order[i]), 32'(exp_order[i]));
        end
        check_val("arb_bubble", 32'(ack_cyc[5] - ack_cyc[4]), 4);
        step(2);
        check_val("arb_quiet", 32'({if_ack, d_ack, mu_start}), 0);

        // Unmapped write: rejected locally, never reaches the memory unit
        d_addr = 27'hC01600;
        d_data = 32'hDEADBEEF;
        d_we   = 1'b1;
        d_req  = 1'b1;
        s0 = start_cycles;
        wait_ack(5, cyc);
        check_val("unmap_acks", 32'({if_ack, d_ack, bus_err}), 32'b011);
        check_val("unmap_d_q", d_q, 0);
        check_val("unmap_latency", 32'(cyc), 1);
        check_val("unmap_no_start", 32'(start_cycles - s0), 0);
        check_val("unmap_we_dropped", 32'(mu_we), 0);
        d_req = 1'b0;
        d_we  = 1'b0;
        step(1);
        check_val("unmap_err_pulse", 32'({d_ack, bus_err}), 0);

        // Last mapped word is serviced normally
        d_addr = 27'hC015FF;
        mu_q   = 32'h0BADCAFE;
        d_req  = 1'b1;
        wait_ack(10, cyc);
        check_val("edge_acks", 32'({if_ack, d_ack, bus_err}), 32'b010);
        check_val("edge_d_q", d_q, 32'h0BADCAFE);
        d_req = 1'b0;
        step(1);

        // Hung access: busy stuck high until the timeout aborts it
        mem_stuck = 1'b1;
        mu_q      = 32'h77777777;
        if_addr   = 27'h000400;
        if_req    = 1'b1;
        s0 = start_cycles;
        wait_ack(40, cyc);
        check_val("tmo_acks", 32'({if_ack, d_ack, bus_err}), 32'b101);
        check_val("tmo_if_q", if_q, 0);
        check_val("tmo_start_low", 32'(mu_start), 0);
        check_val("tmo_start_cycles", 32'(start_cycles - s0), TMO);
        check_val("tmo_latency", 32'(cyc), TMO + 1);
        if_req    = 1'b0;
        mem_stuck = 1'b0;
        step(1);

        // Recovery after the timeout
        d_addr = 27'h000500;
        mu_q   = 32'h600DF00D;
        d_req  = 1'b1;
        s0 = start_cycles;
        wait_ack(10, cyc);
        check_val("recov_acks", 32'({if_ack, d_ack, bus_err}), 32'b010);
        check_val("recov_d_q", d_q, 32'h600DF00D);
        check_val("recov_start_cycles", 32'(start_cycles - s0), 2);
        d_req = 1'b0;
        step(1);

        // Reset asserted while the access sits in WAIT
        mem_stuck = 1'b1;
        d_addr    = 27'h000600;
        d_req     = 1'b1;
        step(3);
        check_val("rstw_pre_start", 32'(mu_start), 1);
        #2;
        reset        = 1'b0;
        mu_init_done = 1'b0;
        #1;
        check_val("rstw_async_start", 32'(mu_start), 0);
        d_req     = 1'b0;
        mem_stuck = 1'b0;
        step(2);
        check_val("rstw_no_ack", 32'({if_ack, d_ack, bus_err}), 0);
        check_val("rstw_d_q", d_q, 0);
        @(negedge clk);
        reset = 1'b1;
        mu_q  = 32'h13579BDF;
        d_req = 1'b1;
        s0 = start_cycles;
        step(3);
        check_val("rstw_init_wait", 32'(start_cycles - s0), 0);
        mu_init_done = 1'b1;
        wait_ack(10, cyc);
        check_val("rstw_reissue_acks", 32'({if_ack, d_ack, bus_err}), 32'b010);
        check_val("rstw_reissue_d_q", d_q, 32'h13579BDF);
        d_req = 1'b0;
        step(2);

        check_val("never_both_acks", 32'(both_ack_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
